// File: rtl/hdmi_ser_pkg.sv
// Shared constants and helpers for the fabric HDMI serializer.
// Holds the TMDS control tokens, default geometry and the first-sent-bit helper.
package hdmi_ser_pkg;

  localparam int DEFAULT_WIDTH    = 10;
  localparam int DEFAULT_CHANNELS = 3;

  // Widest word first_bit() can look at.
  localparam int MAX_WIDTH        = 32;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  // Bit of a width-bit word that goes out on the wire first.
  function automatic logic first_bit(input logic [MAX_WIDTH-1:0] word,
                                     input int                   width,
                                     input logic                 lsb_first);
    logic [$clog2(MAX_WIDTH)-1:0] msb_idx;
    msb_idx = $clog2(MAX_WIDTH)'(width - 1);
    return lsb_first ? word[0] : word[msb_idx];
  endfunction

endpackage

// File: rtl/hdmi_ser_lane.sv
// One serial lane: a WIDTH-bit shifter with a registered output bit.
// q always presents the current bit, so the shifter feeds q from the next position.
module hdmi_ser_lane
  import hdmi_ser_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter bit               LSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(CTRL_00)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_word,
  output logic             q
);

  logic [WIDTH-1:0] sh;

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh <= IDLE_WORD;
      q  <= first_bit(MAX_WIDTH'(IDLE_WORD), WIDTH, LSB_FIRST);
    end else if (load) begin
      sh <= load_word;
      q  <= first_bit(MAX_WIDTH'(load_word), WIDTH, LSB_FIRST);
    end else if (shift) begin
      if (LSB_FIRST) begin
        sh <= {1'b0, sh[WIDTH-1:1]};
        q  <= sh[1];
      end else begin
        sh <= {sh[WIDTH-2:0], 1'b0};
        q  <= sh[WIDTH-2];
      end
    end
  end

endmodule

// File: rtl/hdmi_fabric_serializer.sv
// Single-clock fabric serializer: double-buffered word intake, per-lane shifters,
// forwarded clock lane and IDLE_WORD substitution. Macro HDMI_SER_UNDERRUN_CNT_EN adds underrun_cnt.
module hdmi_fabric_serializer
  import hdmi_ser_pkg::*;
#(
  parameter int               CHANNELS  = DEFAULT_CHANNELS,
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter bit               LSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(CTRL_00)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      en,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [CHANNELS*WIDTH-1:0] s_data,
  output logic [CHANNELS-1:0]       q,
  output logic                      q_clk,
  output logic                      word_start,
  output logic                      underrun,
  input  logic                      clr_underrun,
  output logic [15:0]               underrun_cnt
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] HALF  = CNT_W'(WIDTH / 2);

  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          cnt_next;
  logic                      boundary;
  logic                      load;
  logic                      accept;
  logic                      underrun_evt;
  logic                      full;
  logic [CHANNELS*WIDTH-1:0] hold_word;

  assign boundary     = (cnt == LAST);
  assign load         = boundary & full & en;
  assign underrun_evt = boundary & en & ~full;
  // Gated by RST so the source sees no ready while the block is held in reset.
  assign s_ready      = ~RST & en & (~full | load);
  assign accept       = s_valid & s_ready;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_next = cnt + CNT_W'(1);
    if (boundary) cnt_next = '0;
  end

  // q_clk and word_start describe the bit position q will carry after this edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt        <= '0;
      q_clk      <= 1'b1;
      word_start <= 1'b1;
    end else begin
      cnt        <= cnt_next;
      q_clk      <= (cnt_next < HALF);
      word_start <= (cnt_next == '0);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         full <= 1'b0;
    else if (accept) full <= 1'b1;
    else if (load)   full <= 1'b0;
  end

  // NOTE: the holding data needs no reset; full alone decides whether it is ever sent.
  always_ff @(posedge CLK) begin
    if (accept) hold_word <= s_data;
  end

  // A clear in the same cycle as a new underrun wins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)               underrun <= 1'b0;
    else if (clr_underrun) underrun <= 1'b0;
    else if (underrun_evt) underrun <= 1'b1;
  end

`ifdef HDMI_SER_UNDERRUN_CNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                         underrun_cnt <= '0;
    else if (clr_underrun)                           underrun_cnt <= '0;
    else if (underrun_evt && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
  end
`else
  assign underrun_cnt = 16'h0000;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    hdmi_ser_lane #(
      .WIDTH     (WIDTH),
      .LSB_FIRST (LSB_FIRST),
      .IDLE_WORD (IDLE_WORD)
    ) u_lane (
      .clk       (CLK),
      .rst       (RST),
      .load      (boundary),
      .shift     (~boundary),
      .load_word (load ? hold_word[i*WIDTH +: WIDTH] : IDLE_WORD),
      .q         (q[i])
    );
  end

endmodule

// File: tb/tb_hdmi_fabric_serializer.sv
// Self-checking bench for hdmi_fabric_serializer: randomized traffic against a word-level model,
// plus an MSB-first 8-bit x 4-lane instance. Honours HDMI_SER_UNDERRUN_CNT_EN.
module tb_hdmi_fabric_serializer;
  import hdmi_ser_pkg::*;

  localparam int         W      = 10;
  localparam int         C      = 3;
  localparam logic [9:0] IDLE   = CTRL_00;
  localparam int         WB     = 8;
  localparam int         CB     = 4;
  localparam logic [7:0] IDLE_B = 8'h3C;

`ifdef HDMI_SER_UNDERRUN_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic           en = 1'b0, s_valid = 1'b0, clr_underrun = 1'b0;
  logic [C*W-1:0] s_data = '0;
  logic           s_ready, q_clk, word_start, underrun;
  logic [C-1:0]   q;
  logic [15:0]    underrun_cnt;

  logic             en_b = 1'b0, s_valid_b = 1'b0, clr_b = 1'b0;
  logic [CB*WB-1:0] s_data_b = '0;
  logic             s_ready_b, q_clk_b, word_start_b, underrun_b;
  logic [CB-1:0]    q_b;
  logic [15:0]      underrun_cnt_b;

  hdmi_fabric_serializer #(.CHANNELS(C), .WIDTH(W), .LSB_FIRST(1'b1), .IDLE_WORD(IDLE)) dut (
    .CLK(CLK), .RST(RST), .en(en), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .q(q), .q_clk(q_clk), .word_start(word_start), .underrun(underrun),
    .clr_underrun(clr_underrun), .underrun_cnt(underrun_cnt));

  hdmi_fabric_serializer #(.CHANNELS(CB), .WIDTH(WB), .LSB_FIRST(1'b0), .IDLE_WORD(IDLE_B)) dut_b (
    .CLK(CLK), .RST(RST), .en(en_b), .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
    .q(q_b), .q_clk(q_clk_b), .word_start(word_start_b), .underrun(underrun_b),
    .clr_underrun(clr_b), .underrun_cnt(underrun_cnt_b));

  int vectors = 0;
  int miscompares = 0;

  // Word-level model: the word on the wire, its bit position, the one-deep holding slot.
  int             m_pos;
  logic [C*W-1:0] m_cur, m_hold;
  bit             m_full, m_und, m_acc, m_loaded;
  int             m_cnt;
  int             tick_no = 0;

  // Clock edges since reset, used to locate word boundaries of the second instance.
  int b_edges;
  always @(posedge CLK or posedge RST)
    if (RST) b_edges <= 0;
    else     b_edges <= b_edges + 1;

  task automatic model_reset();
    m_pos = 0; m_cur = {C{IDLE}}; m_full = 0; m_und = 0; m_cnt = 0; m_acc = 0; m_loaded = 0;
  endtask

  // One clock: check s_ready, advance the model over the edge, check the outputs after it.
  task automatic tick();
    bit rdy, und_evt;
    #1;
    rdy = en && (!m_full || m_pos == W-1);
    vectors++;
    if (s_ready !== rdy) begin
      miscompares++;
      $display("FAIL s_ready tick=%0d got=%b exp=%b", tick_no, s_ready, rdy);
    end
    m_acc = s_valid && rdy;
    und_evt = 0;
    m_loaded = 0;
    if (m_pos == W-1) begin
      if (en && m_full) begin m_cur = m_hold; m_loaded = 1; end
      else m_cur = {C{IDLE}};
      und_evt = en && !m_full;
    end
    if (m_acc) begin m_hold = s_data; m_full = 1; end
    else if (m_loaded) m_full = 0;
    if (clr_underrun) begin m_und = 0; m_cnt = 0; end
    else if (und_evt) begin
      m_und = 1;
      if (CNT_ON && m_cnt < 65535) m_cnt++;
    end
    m_pos = (m_pos + 1) % W;
    tick_no++;
    @(posedge CLK);
    @(negedge CLK);
    for (int i = 0; i < C; i++) begin
      vectors++;
      if (q[i] !== m_cur[i*W + m_pos]) begin
        miscompares++;
        $display("FAIL q[%0d] tick=%0d pos=%0d got=%b exp=%b", i, tick_no, m_pos, q[i], m_cur[i*W + m_pos]);
      end
    end
    vectors++;
    if (q_clk !== (m_pos < W/2)) begin
      miscompares++;
      $display("FAIL q_clk tick=%0d pos=%0d got=%b", tick_no, m_pos, q_clk);
    end
    vectors++;
    if (word_start !== (m_pos == 0)) begin
      miscompares++;
      $display("FAIL word_start tick=%0d pos=%0d got=%b", tick_no, m_pos, word_start);
    end
    vectors++;
    if (underrun !== m_und) begin
      miscompares++;
      $display("FAIL underrun tick=%0d got=%b exp=%b", tick_no, underrun, m_und);
    end
    vectors++;
    if (underrun_cnt !== 16'(m_cnt)) begin
      miscompares++;
      $display("FAIL underrun_cnt tick=%0d got=%0d exp=%0d", tick_no, underrun_cnt, m_cnt);
    end
  endtask

  task automatic test_reset();
    en = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    vectors++;
    if (q !== {C{IDLE[0]}} || q_clk !== 1'b1 || word_start !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_outputs got q=%b q_clk=%b ws=%b exp q=%b q_clk=1 ws=1", q, q_clk, word_start, {C{IDLE[0]}});
    end
    vectors++;
    if (underrun !== 1'b0 || underrun_cnt !== 16'h0 || s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status got ur=%b cnt=%0d rdy=%b exp 0/0/0", underrun, underrun_cnt, s_ready);
    end
    en = 1'b0;
    RST = 1'b0;
    model_reset();
    // Disabled, no traffic: IDLE_WORD on every lane and a free-running q_clk.
    for (int i = 0; i < 30; i++) tick();
  endtask

  task automatic test_directed();
    logic [W-1:0] got [C];
    logic [W-1:0] exp_w [C];
    bit ok;
    exp_w[0] = 10'h3FF; exp_w[1] = 10'h000; exp_w[2] = 10'h2AA;
    en = 1'b1;
    s_data = {exp_w[2], exp_w[1], exp_w[0]};
    s_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = m_acc; end
    s_valid = 1'b0;
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL directed_accept got=no accept exp=accept within 20 cycles"); end
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin tick(); ok = m_loaded; end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL directed_load got=no load exp=load within 30 cycles"); end
    for (int k = 0; k < W; k++) begin
      if (k > 0) tick();
      for (int i = 0; i < C; i++) got[i][k] = q[i];
    end
    for (int i = 0; i < C; i++) begin
      vectors++;
      if (got[i] !== exp_w[i]) begin
        miscompares++;
        $display("FAIL directed_lane%0d got=%h exp=%h", i, got[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_stream();
    int accepts, last;
    accepts = 0;
    last = -1;
    clr_underrun = 1'b1;
    s_valid = 1'b1;
    s_data = (C*W)'($urandom());
    for (int i = 0; i < 1200 && accepts < 100; i++) begin
      tick();
      clr_underrun = 1'b0;
      if (m_acc) begin
        accepts++;
        if (accepts >= 3) begin
          vectors++;
          if (tick_no - last != W) begin
            miscompares++;
            $display("FAIL stream_gap got=%0d exp=%0d", tick_no - last, W);
          end
        end
        last = tick_no;
        s_data = (C*W)'($urandom());
      end
    end
    vectors++;
    if (accepts != 100) begin miscompares++; $display("FAIL stream_accepts got=%0d exp=100", accepts); end
    vectors++;
    if (underrun !== 1'b0) begin miscompares++; $display("FAIL stream_underrun got=%b exp=0", underrun); end
  endtask

  task automatic test_underrun();
    bit ok;
    s_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin tick(); ok = m_und; end
    s_valid = 1'b1;
    s_data = (C*W)'($urandom());
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = m_acc; end
    s_valid = 1'b0;
    vectors++;
    if (underrun !== 1'b1 || underrun_cnt !== (CNT_ON ? 16'd1 : 16'd0)) begin
      miscompares++;
      $display("FAIL underrun_once got ur=%b cnt=%0d exp ur=1 cnt=%0d", underrun, underrun_cnt, CNT_ON ? 1 : 0);
    end
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    vectors++;
    if (underrun !== 1'b0 || underrun_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL underrun_clear got ur=%b cnt=%0d exp 0/0", underrun, underrun_cnt);
    end
    // Clear landing on an underrun boundary must win.
    for (int i = 0; i < 30 && !(m_pos == W-1 && !m_full); i++) tick();
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    vectors++;
    if (underrun !== 1'b0 || underrun_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL clear_wins got ur=%b cnt=%0d exp 0/0", underrun, underrun_cnt);
    end
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_reset_midword();
    s_data = {C{10'h3FF}};
    s_valid = 1'b1;
    for (int i = 0; i < 40 && !(m_full && m_pos == 5); i++) tick();
    #2 RST = 1'b1;
    #1;
    vectors++;
    if (q !== {C{IDLE[0]}} || q_clk !== 1'b1 || word_start !== 1'b1 || underrun !== 1'b0
        || underrun_cnt !== 16'h0 || s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset got q=%b q_clk=%b ws=%b ur=%b cnt=%0d rdy=%b", q, q_clk, word_start,
               underrun, underrun_cnt, s_ready);
    end
    s_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    // The discarded 3FF word must never appear: the model expects IDLE_WORD only.
    for (int i = 0; i < 25; i++) tick();
  endtask

  task automatic test_msb_first();
    logic [WB-1:0] got [CB];
    logic [WB-1:0] clk_seq, ws_seq;
    int k_acc, skip;
    bit ok;
    en_b = 1'b1;
    s_data_b = {CB{8'h81}};
    s_valid_b = 1'b1;
    ok = 0;
    k_acc = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      ok = s_ready_b;
      k_acc = b_edges % WB;
      @(posedge CLK);
      @(negedge CLK);
    end
    s_valid_b = 1'b0;
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL msb_accept got=no accept exp=accept within 20 cycles"); end
    skip = (k_acc == WB-1) ? 1 : 0;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (b_edges % WB == 0) begin
        if (skip == 0) ok = 1;
        else skip--;
      end
    end
    for (int k = 0; k < WB; k++) begin
      if (k > 0) begin @(posedge CLK); @(negedge CLK); end
      for (int i = 0; i < CB; i++) got[i][WB-1-k] = q_b[i];
      clk_seq[WB-1-k] = q_clk_b;
      ws_seq[WB-1-k] = word_start_b;
    end
    for (int i = 0; i < CB; i++) begin
      vectors++;
      if (got[i] !== 8'h81) begin miscompares++; $display("FAIL msb_lane%0d got=%h exp=81", i, got[i]); end
    end
    vectors++;
    if (clk_seq !== 8'hF0) begin miscompares++; $display("FAIL msb_q_clk got=%b exp=11110000", clk_seq); end
    vectors++;
    if (ws_seq !== 8'h80) begin miscompares++; $display("FAIL msb_word_start got=%b exp=10000000", ws_seq); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream();
    test_underrun();
    test_reset_midword();
    test_msb_first();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
